// File: rtl/wrap_pkg.sv
// Shared definitions for the core test wrapper: TAP state encoding,
// instruction opcodes (4-bit, zero-extended to IR_WIDTH) and the IR capture pattern.
package wrap_pkg;

    typedef enum logic [3:0] {
        TAP_TLR,      TAP_RTI,
        TAP_SEL_DR,   TAP_CAP_DR,   TAP_SHIFT_DR, TAP_EX1_DR,
        TAP_PAUSE_DR, TAP_EX2_DR,   TAP_UPD_DR,
        TAP_SEL_IR,   TAP_CAP_IR,   TAP_SHIFT_IR, TAP_EX1_IR,
        TAP_PAUSE_IR, TAP_EX2_IR,   TAP_UPD_IR
    } tap_state_e;

    localparam logic [3:0] OP_EXTEST   = 4'h0;
    localparam logic [3:0] OP_SAMPLE   = 4'h1;
    localparam logic [3:0] OP_INTEST   = 4'h2;
    localparam logic [3:0] OP_IDCODE   = 4'h3;
    localparam logic [3:0] OP_USER_TDR = 4'h4;

    localparam logic [3:0] IR_CAPTURE  = 4'b0001;

endpackage

// File: rtl/wrap_tap_fsm.sv
// 16-state TAP controller. Strobes decode the current state; tap_reset flags
// any edge that lands in (or stays in) Test-Logic-Reset.
module wrap_tap_fsm
    import wrap_pkg::*;
(
    input  logic TCLK,
    input  logic TRESETN,
    input  logic TMS,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir,
    output logic tap_reset
);

    tap_state_e state, state_nxt;

    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) state <= TAP_TLR;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        case (state)
            TAP_TLR:      state_nxt = TMS ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      state_nxt = TMS ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   state_nxt = TMS ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   begin capture_dr = 1'b1; state_nxt = TMS ? TAP_EX1_DR : TAP_SHIFT_DR; end
            TAP_SHIFT_DR: begin shift_dr   = 1'b1; state_nxt = TMS ? TAP_EX1_DR : TAP_SHIFT_DR; end
            TAP_EX1_DR:   state_nxt = TMS ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_nxt = TMS ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   state_nxt = TMS ? TAP_UPD_DR : TAP_SHIFT_DR;
            TAP_UPD_DR:   begin update_dr  = 1'b1; state_nxt = TMS ? TAP_SEL_DR : TAP_RTI; end
            TAP_SEL_IR:   state_nxt = TMS ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   begin capture_ir = 1'b1; state_nxt = TMS ? TAP_EX1_IR : TAP_SHIFT_IR; end
            TAP_SHIFT_IR: begin shift_ir   = 1'b1; state_nxt = TMS ? TAP_EX1_IR : TAP_SHIFT_IR; end
            TAP_EX1_IR:   state_nxt = TMS ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_nxt = TMS ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   state_nxt = TMS ? TAP_UPD_IR : TAP_SHIFT_IR;
            TAP_UPD_IR:   begin update_ir  = 1'b1; state_nxt = TMS ? TAP_SEL_DR : TAP_RTI; end
            default:      state_nxt = TAP_TLR;
        endcase
    end

    // Clearing on entry means five TMS=1 edges leave every register already reset.
    assign tap_reset = (state_nxt == TAP_TLR);

endmodule

// File: rtl/wrap_tap_ctrl.sv
// Core test wrapper: TAP, IR, BYPASS/IDCODE/user TDR and a NUM_IN+NUM_OUT cell WBR.
// Define WRAP_IDCODE_EN to build the IDCODE register and make IDCODE the reset instruction.
module wrap_tap_ctrl
    import wrap_pkg::*;
#(
    parameter int          NUM_IN     = 3,
    parameter int          NUM_OUT    = 3,
    parameter int          IR_WIDTH   = 4,
    parameter int          TDR_WIDTH  = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h0000_00CB
) (
    input  logic                 TCLK,
    input  logic                 TRESETN,
    input  logic                 TMS,
    input  logic                 WSI,
    output logic                 WSO,
    input  logic [NUM_IN-1:0]    pad_in,
    output logic [NUM_IN-1:0]    pad_in_core,
    input  logic [NUM_OUT-1:0]   core_out,
    output logic [NUM_OUT-1:0]   pad_out,
    output logic [TDR_WIDTH-1:0] tdr_po
);

    localparam int WBR_W = NUM_IN + NUM_OUT;
`ifdef WRAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] RESET_INSTR = IR_WIDTH'(OP_IDCODE);
`else
    localparam logic [IR_WIDTH-1:0] RESET_INSTR = '1;
`endif

    logic capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir, tap_reset;

    wrap_tap_fsm u_fsm (
        .TCLK       (TCLK),
        .TRESETN    (TRESETN),
        .TMS        (TMS),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .tap_reset  (tap_reset)
    );

    logic [IR_WIDTH-1:0]  ir_sr, ir_active;
    logic                 byp;
    logic [TDR_WIDTH-1:0] tdr_sr;
    logic [WBR_W-1:0]     wbr_sr, wbr_upd;
    logic                 is_extest, is_intest, is_sample;
    logic                 sel_wbr, sel_tdr, sel_id, id_bit, dr_bit;

    assign is_extest = (ir_active == IR_WIDTH'(OP_EXTEST));
    assign is_intest = (ir_active == IR_WIDTH'(OP_INTEST));
    assign is_sample = (ir_active == IR_WIDTH'(OP_SAMPLE));
    assign sel_wbr   = is_extest | is_intest | is_sample;
    assign sel_tdr   = (ir_active == IR_WIDTH'(OP_USER_TDR));

    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            ir_sr     <= '0;
            ir_active <= RESET_INSTR;
        end else if (tap_reset) begin
            ir_sr     <= '0;
            ir_active <= RESET_INSTR;
        end else begin
            if (capture_ir)    ir_sr <= IR_WIDTH'(IR_CAPTURE);
            else if (shift_ir) ir_sr <= {WSI, ir_sr[IR_WIDTH-1:1]};
            if (update_ir)     ir_active <= ir_sr;
        end
    end

    // Only the register selected by the active instruction captures or shifts.
    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            byp     <= 1'b0;
            tdr_sr  <= '0;
            tdr_po  <= '0;
            wbr_sr  <= '0;
            wbr_upd <= '0;
        end else if (tap_reset) begin
            byp     <= 1'b0;
            tdr_sr  <= '0;
            tdr_po  <= '0;
            wbr_sr  <= '0;
            wbr_upd <= '0;
        end else begin
            if (capture_dr) begin
                byp <= 1'b0;
                if (sel_tdr) tdr_sr <= tdr_po;
                if (sel_wbr) wbr_sr <= {core_out, pad_in};
            end else if (shift_dr) begin
                if (!sel_tdr && !sel_wbr && !sel_id) byp <= WSI;
                if (sel_tdr) tdr_sr <= {WSI, tdr_sr[TDR_WIDTH-1:1]};
                if (sel_wbr) wbr_sr <= {WSI, wbr_sr[WBR_W-1:1]};
            end
            if (update_dr && sel_tdr) tdr_po  <= tdr_sr;
            if (update_dr && sel_wbr) wbr_upd <= wbr_sr;
        end
    end

`ifdef WRAP_IDCODE_EN
    logic [31:0] id_sr;

    assign sel_id = (ir_active == IR_WIDTH'(OP_IDCODE));
    assign id_bit = id_sr[0];

    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN)                  id_sr <= '0;
        else if (tap_reset)            id_sr <= '0;
        else if (capture_dr && sel_id) id_sr <= IDCODE_VAL;
        else if (shift_dr && sel_id)   id_sr <= {WSI, id_sr[31:1]};
    end
`else
    wire unused_idcode = ^IDCODE_VAL;

    assign sel_id = 1'b0;
    assign id_bit = 1'b0;
`endif

    assign dr_bit = sel_id  ? id_bit    :
                    sel_tdr ? tdr_sr[0] :
                    sel_wbr ? wbr_sr[0] : byp;

    always_ff @(negedge TCLK or negedge TRESETN) begin
        if (!TRESETN)      WSO <= 1'b0;
        else if (shift_ir) WSO <= ir_sr[0];
        else if (shift_dr) WSO <= dr_bit;
        else               WSO <= 1'b0;
    end

    assign pad_out     = (is_extest | is_intest) ? wbr_upd[WBR_W-1:NUM_IN] : core_out;
    assign pad_in_core = is_intest ? wbr_upd[NUM_IN-1:0] : pad_in;

endmodule
